// File: rtl/pool_pkg.sv
// Shared definitions for the 2x2 pooling window feeder: FSM states,
// frame timing constants and the default data width.
package pool_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIN
    } pool_state_t;

    // One pooling frame per window: idle slot, four element slots, write slot.
    localparam int POOL_FRAME_LEN      = 6;
    localparam int POOL_DATA_W_DEFAULT = 32;

    localparam int SLOT_W = $clog2(POOL_FRAME_LEN);

    // Slots 0..3 issue element reads; slot 5 writes the pooled result.
    localparam logic [SLOT_W-1:0] SLOT_RD_END = SLOT_W'(4);
    localparam logic [SLOT_W-1:0] SLOT_LAST   = SLOT_W'(POOL_FRAME_LEN - 1);

endpackage

// File: rtl/pool_addr_gen.sv
// Window element and result address generation for pool_window_feeder.
// Element k of window (r,c) sits at row 2r+k[1], column 2c+k[0]; all
// address arithmetic wraps modulo 2^ADDR_W.
module pool_addr_gen
    import pool_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DIM_W  = 8
) (
    input  logic [DIM_W-1:0]  r,
    input  logic [DIM_W-1:0]  c,
    input  logic [SLOT_W-1:0] slot,
    input  logic [DIM_W-1:0]  map_w,
    input  logic [DIM_W-1:0]  map_h,
    input  logic [DIM_W-1:0]  out_w,
    input  logic [ADDR_W-1:0] src_base,
    input  logic [ADDR_W-1:0] dst_base,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              pad
);

    localparam int WIDE_W = ADDR_W + 2 * DIM_W + 2;

    logic [DIM_W:0]    row;
    logic [DIM_W:0]    col;
    logic [WIDE_W-1:0] rd_full;
    logic [WIDE_W-1:0] wr_full;

    // Map (window, slot) to source/result addresses and flag elements outside the map.
    always_comb begin
        row     = {r, slot[1]};
        col     = {c, slot[0]};
        pad     = (slot < SLOT_RD_END) &&
                  ((row >= {1'b0, map_h}) || (col >= {1'b0, map_w}));
        rd_full = WIDE_W'(src_base) + WIDE_W'(row) * WIDE_W'(map_w) + WIDE_W'(col);
        wr_full = WIDE_W'(dst_base) + WIDE_W'(r) * WIDE_W'(out_w) + WIDE_W'(c);
        rd_addr = rd_full[ADDR_W-1:0];
        wr_addr = wr_full[ADDR_W-1:0];
    end

endmodule

// File: rtl/pool_window_feeder.sv
// Streams non-overlapping 2x2 windows of a feature map into a pooler,
// one 6-slot frame per window, and writes each pooled result back.
// Optional feature: define POOL_FEED_PAD_EN to round the output size up
// and feed out-of-map elements as zero instead of dropping odd edges.
module pool_window_feeder
    import pool_pkg::*;
#(
    parameter int DATA_W = POOL_DATA_W_DEFAULT,
    parameter int ADDR_W = 16,
    parameter int DIM_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DIM_W-1:0]  map_w,
    input  logic [DIM_W-1:0]  map_h,
    input  logic [ADDR_W-1:0] src_base,
    input  logic [ADDR_W-1:0] dst_base,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              pool_en,
    output logic [DATA_W-1:0] pool_data,
    input  logic [DATA_W-1:0] pool_result,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              done
);

    pool_state_t state;
    pool_state_t state_nxt;

    logic [SLOT_W-1:0] slot;
    logic [DIM_W-1:0]  r;
    logic [DIM_W-1:0]  c;
    logic              pad_q;

    logic [DIM_W-1:0]  cfg_w;
    logic [DIM_W-1:0]  cfg_h;
    logic [DIM_W-1:0]  cfg_out_w;
    logic [DIM_W-1:0]  cfg_out_h;
    logic [ADDR_W-1:0] cfg_src;
    logic [ADDR_W-1:0] cfg_dst;

    logic [DIM_W-1:0]  in_out_w;
    logic [DIM_W-1:0]  in_out_h;

    logic [ADDR_W-1:0] gen_rd_addr;
    logic [ADDR_W-1:0] gen_wr_addr;
    logic              gen_pad;

    logic              accept;
    logic              last_slot;
    logic              last_col;
    logic              last_row;

`ifdef POOL_FEED_PAD_EN
    // Round up so a trailing odd row/column still gets its own (padded) window.
    always_comb begin
        in_out_w = DIM_W'(({1'b0, map_w} + (DIM_W + 1)'(1)) >> 1);
        in_out_h = DIM_W'(({1'b0, map_h} + (DIM_W + 1)'(1)) >> 1);
    end
`else
    // Round down so the odd last row/column is simply never visited.
    always_comb begin
        in_out_w = map_w >> 1;
        in_out_h = map_h >> 1;
    end
`endif

    pool_addr_gen #(
        .ADDR_W (ADDR_W),
        .DIM_W  (DIM_W)
    ) u_addr_gen (
        .r        (r),
        .c        (c),
        .slot     (slot),
        .map_w    (cfg_w),
        .map_h    (cfg_h),
        .out_w    (cfg_out_w),
        .src_base (cfg_src),
        .dst_base (cfg_dst),
        .rd_addr  (gen_rd_addr),
        .wr_addr  (gen_wr_addr),
        .pad      (gen_pad)
    );

    // Position flags within the current frame and scan.
    always_comb begin
        accept    = (state == IDLE) && start;
        last_slot = (slot == SLOT_LAST);
        last_col  = (c == cfg_out_w - DIM_W'(1));
        last_row  = (r == cfg_out_h - DIM_W'(1));
    end

    // State register; reset drops straight to IDLE so a run is abandoned at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Config latch, slot/window counters and the pad flag of the previous slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot      <= '0;
            r         <= '0;
            c         <= '0;
            pad_q     <= 1'b0;
            cfg_w     <= '0;
            cfg_h     <= '0;
            cfg_out_w <= '0;
            cfg_out_h <= '0;
            cfg_src   <= '0;
            cfg_dst   <= '0;
        end else begin
            pad_q <= gen_pad;
            if (accept) begin
                cfg_w     <= map_w;
                cfg_h     <= map_h;
                cfg_out_w <= in_out_w;
                cfg_out_h <= in_out_h;
                cfg_src   <= src_base;
                cfg_dst   <= dst_base;
                slot      <= '0;
                r         <= '0;
                c         <= '0;
            end else if (state == RUN) begin
                if (last_slot) begin
                    slot <= '0;
                    if (last_col) begin
                        c <= '0;
                        r <= last_row ? '0 : r + DIM_W'(1);
                    end else begin
                        c <= c + DIM_W'(1);
                    end
                end else begin
                    slot <= slot + SLOT_W'(1);
                end
            end
        end
    end

    // Next state and all outputs; everything is gated by state so non-RUN cycles are quiet.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        rd_en     = 1'b0;
        rd_addr   = '0;
        pool_en   = 1'b0;
        pool_data = '0;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = ((in_out_w == '0) || (in_out_h == '0)) ? FIN : RUN;
                end
            end
            RUN: begin
                busy    = 1'b1;
                pool_en = 1'b1;
                if ((slot < SLOT_RD_END) && !gen_pad) begin
                    rd_en   = 1'b1;
                    rd_addr = gen_rd_addr;
                end
                // Data read in the previous slot arrives now; padded elements read as zero.
                if ((slot != '0) && !last_slot && !pad_q) begin
                    pool_data = rd_data;
                end
                if (last_slot) begin
                    wr_en   = 1'b1;
                    wr_addr = gen_wr_addr;
                    wr_data = pool_result;
                    if (last_col && last_row) begin
                        state_nxt = FIN;
                    end
                end
            end
            FIN: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule
